// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and sizing helpers for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width for a given operand width; WIDTH >= 2 keeps this >= 1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic borrowin,
  output logic diff,
  output logic borrowout
);

  assign diff      = x ^ y ^ borrowin;
  assign borrowout = (~x & y) | (~(x ^ y) & borrowin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first, start/busy/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    count;
  logic             borrow_ff, a_msb, b_msb;
  logic             d, borrow_nxt, accept, last;

  full_subtractor u_fs (
    .x         (a_sr[0]),
    .y         (b_sr[0]),
    .borrowin  (borrow_ff),
    .diff      (d),
    .borrowout (borrow_nxt)
  );

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (count == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Published results change only on the edge that processes the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      borrow_ff  <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sr      <= a;
      b_sr      <= b;
      borrow_ff <= borrow_in;
      count     <= '0;
      a_msb     <= a[WIDTH-1];
      b_msb     <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr    <= {d, res_sr[WIDTH-1:1]};
      borrow_ff <= borrow_nxt;
      count     <= count + 1'b1;
      if (last) begin
        diff       <= {d, res_sr[WIDTH-1:1]};
        borrow_out <= borrow_nxt;
        overflow   <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

endmodule
